// File: rtl/execute_multicycle_pkg.sv
// exec_pkg: shared constants and types for the multicycle execute stage.
//   - funct codes recognised by the ALU and the multiply/HI path
//   - aluOp encodings coming from the main decoder
//   - operand forwarding select codes and the priority helper
//   - FSM state type for the multiply sequencer
package exec_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ORI    = 2'b11;

  localparam logic [1:0] FWD_NOMINAL = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exec_state_t;

  // The younger producer (EX/MEM) always wins over MEM/WB.
  function automatic logic [1:0] fwd_select(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else return FWD_NOMINAL;
  endfunction

endpackage

// File: rtl/execute_multicycle_if.sv
// execute_multicycle_if: bundle of every execute-stage signal except clk/rstN.
//   ID/EX side  : flush, idExValid, control fields, operands, register specifiers
//   MEM/WB side : memWbRegWrite, memWbRd, memWbData
//   EX/MEM side : exMemValid, control outputs, result, writeData, rdOut
//   stall       : back-pressure to PC, IF/ID and ID/EX
// master = upstream pipeline driving the stage, slave = the execute stage.
interface execute_multicycle_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;
  logic                  idExValid;
  logic [1:0]            writeBackControlIn;
  logic [1:0]            memAccessControlIn;
  logic [3:0]            calculationControl;
  logic [DATA_W-1:0]     readData1;
  logic [DATA_W-1:0]     readData2;
  logic [DATA_W-1:0]     immediateOperand;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rdIn;
  logic                  memWbRegWrite;
  logic [REG_ADDR_W-1:0] memWbRd;
  logic [DATA_W-1:0]     memWbData;
  logic                  stall;
  logic                  exMemValid;
  logic [1:0]            writeBackControlOut;
  logic [1:0]            memAccessControlOut;
  logic [DATA_W-1:0]     result;
  logic [DATA_W-1:0]     writeData;
  logic [REG_ADDR_W-1:0] rdOut;

  modport master (
    output flush, idExValid, writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    input  stall, exMemValid, writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );

  modport slave (
    input  flush, idExValid, writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    output stall, exMemValid, writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );
endinterface

// File: rtl/execute_multicycle_alu.sv
// Alu: single-cycle integer ALU, DATA_W wide, results wrap modulo 2^DATA_W.
//   a, b   : operands
//   aluOp  : 00 add (mem), 01 sub (branch), 10 R-type by funct, 11 or (ori)
//   funct  : R-type function code
//   y      : result
module Alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        aluOp,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] y
);

  // Pure combinational decode; unknown R-type functs fall back to add.
  always_comb begin
    y = a + b;
    case (aluOp)
      ALUOP_MEM:    y = a + b;
      ALUOP_BRANCH: y = a - b;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: y = a + b;
          FUNCT_SUB, FUNCT_SUBU: y = a - b;
          FUNCT_AND:             y = a & b;
          FUNCT_OR:              y = a | b;
          FUNCT_XOR:             y = a ^ b;
          FUNCT_NOR:             y = ~(a | b);
          FUNCT_SLT:             y = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
          FUNCT_SLTU:            y = {{(DATA_W-1){1'b0}}, a < b};
          default:               y = a + b;
        endcase
      end
      ALUOP_ORI:    y = a | b;
      default:      y = a + b;
    endcase
  end

endmodule

// File: rtl/execute_multicycle_mul_iter.sv
// mul_iter: radix-2 shift-add unsigned multiplier, one iteration per falling edge.
//   clk, rstN : pipeline clock (negedge) and async active-low reset
//   start     : latch a/b and begin DATA_W iterations
//   flush     : abort any multiply in progress
//   a, b      : operands, sampled only on the start edge
//   done      : final iteration happens on the coming edge
//   product   : 2*DATA_W-bit product, valid once the count has reached zero
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    count;

  // Multiplicand shifts left and multiplier shifts right, so only bit 0 of
  // the multiplier ever decides whether to accumulate.
  always_ff @(negedge clk or negedge rstN) begin
    if (!rstN) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (start) begin
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= CNT_W'(DATA_W);
    end else if (count != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - 1'b1;
    end
  end

  assign done    = (count == CNT_W'(1));
  assign product = acc;

endmodule

// File: rtl/execute_multicycle.sv
// execute_multicycle: execute stage with two-level forwarding, a single-cycle
// ALU path and an iterative MULTU that stalls upstream and writes HI.
//   clk  : pipeline clock, all state updates on the falling edge
//   rstN : asynchronous active-low reset
//   bus  : slave side of execute_multicycle_if (ID/EX in, MEM/WB in, EX/MEM out, stall)
module execute_multicycle
  import exec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic                  clk,
  input logic                  rstN,
  execute_multicycle_if.slave  bus
);

  logic                  reg_dst, alu_src;
  logic [1:0]            alu_op;
  logic [5:0]            funct;
  logic                  is_mult, is_mfhi;
  exec_state_t           state;
  logic                  ex_valid;
  logic [1:0]            ex_wb, ex_mem;
  logic [DATA_W-1:0]     ex_result, ex_wdata, hi;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  exmem_can_fwd;
  logic [1:0]            sel_a, sel_b;
  logic [DATA_W-1:0]     operand1, operand2, rd2_fwd, alu_y, alu_or_hi;
  logic [REG_ADDR_W-1:0] dest_rd;
  logic                  mul_start, mul_done;
  logic [2*DATA_W-1:0]   product;

  assign {reg_dst, alu_op, alu_src} = bus.calculationControl;
  assign funct   = bus.immediateOperand[5:0];
  assign is_mult = bus.idExValid && (alu_op == ALUOP_RTYPE) && (funct == FUNCT_MULTU);
  assign is_mfhi = bus.idExValid && (alu_op == ALUOP_RTYPE) && (funct == FUNCT_MFHI);

  // A bubble in EX/MEM (valid low) must never forward, and r0 is hard-wired.
  assign exmem_can_fwd = ex_wb[1] && ex_valid && (ex_rd != '0);
  assign sel_a = fwd_select(exmem_can_fwd && (ex_rd == bus.rs),
                            bus.memWbRegWrite && (bus.memWbRd != '0) && (bus.memWbRd == bus.rs));
  assign sel_b = fwd_select(exmem_can_fwd && (ex_rd == bus.rt),
                            bus.memWbRegWrite && (bus.memWbRd != '0) && (bus.memWbRd == bus.rt));

  always_comb begin
    operand1 = bus.readData1;
    rd2_fwd  = bus.readData2;
    case (sel_a)
      FWD_EXMEM: operand1 = ex_result;
      FWD_MEMWB: operand1 = bus.memWbData;
      default:   operand1 = bus.readData1;
    endcase
    case (sel_b)
      FWD_EXMEM: rd2_fwd = ex_result;
      FWD_MEMWB: rd2_fwd = bus.memWbData;
      default:   rd2_fwd = bus.readData2;
    endcase
  end

  assign operand2  = alu_src ? bus.immediateOperand : rd2_fwd;
  assign dest_rd   = reg_dst ? bus.rdIn : bus.rt;
  assign alu_or_hi = is_mfhi ? hi : alu_y;

  Alu #(.DATA_W(DATA_W)) u_alu (
    .a     (operand1),
    .b     (operand2),
    .aluOp (alu_op),
    .funct (funct),
    .y     (alu_y)
  );

  assign mul_start = (state == IDLE) && is_mult && !bus.flush;

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rstN    (rstN),
    .start   (mul_start),
    .flush   (bus.flush),
    .a       (operand1),
    .b       (operand2),
    .done    (mul_done),
    .product (product)
  );

  // In DONE the stall has already dropped, but ID/EX still holds the MULTU,
  // so its control and rd are taken from the live ID/EX inputs on that edge.
  always_ff @(negedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      hi        <= '0;
      ex_valid  <= 1'b0;
      ex_wb     <= '0;
      ex_mem    <= '0;
      ex_result <= '0;
      ex_wdata  <= '0;
      ex_rd     <= '0;
    end else if (bus.flush) begin
      state    <= IDLE;
      ex_valid <= 1'b0;
      ex_wb    <= '0;
      ex_mem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mult || !bus.idExValid) begin
            if (is_mult) state <= BUSY;
            ex_valid <= 1'b0;
            ex_wb    <= '0;
            ex_mem   <= '0;
          end else begin
            ex_valid  <= 1'b1;
            ex_wb     <= bus.writeBackControlIn;
            ex_mem    <= bus.memAccessControlIn;
            ex_result <= alu_or_hi;
            ex_wdata  <= rd2_fwd;
            ex_rd     <= dest_rd;
          end
        end
        BUSY: begin
          if (mul_done) state <= DONE;
          ex_valid <= 1'b0;
          ex_wb    <= '0;
          ex_mem   <= '0;
        end
        DONE: begin
          state     <= IDLE;
          hi        <= product[2*DATA_W-1:DATA_W];
          ex_valid  <= bus.idExValid;
          ex_wb     <= bus.writeBackControlIn;
          ex_mem    <= bus.memAccessControlIn;
          ex_result <= product[DATA_W-1:0];
          ex_wdata  <= rd2_fwd;
          ex_rd     <= dest_rd;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall               = ((state == IDLE) && is_mult) || (state == BUSY);
  assign bus.exMemValid          = ex_valid;
  assign bus.writeBackControlOut = ex_wb;
  assign bus.memAccessControlOut = ex_mem;
  assign bus.result              = ex_result;
  assign bus.writeData           = ex_wdata;
  assign bus.rdOut               = ex_rd;

endmodule

// File: tb/tb_execute_multicycle.sv
// tb_execute_multicycle: directed bench for execute_multicycle at DATA_W=32
// and DATA_W=8. Outputs are sampled just after the rising edge, i.e. half a
// cycle away from the falling edge on which the DUT updates.
module tb_execute_multicycle;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  execute_multicycle_if #(.DATA_W(32), .REG_ADDR_W(5)) bus32 ();
  execute_multicycle_if #(.DATA_W(8),  .REG_ADDR_W(5)) bus8 ();

  execute_multicycle #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus32)
  );

  execute_multicycle #(.DATA_W(8), .REG_ADDR_W(5)) dut8 (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus8)
  );

  // One full DUT edge, then return just after the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [1:0] wb, input logic [1:0] mem,
                         input logic [3:0] calc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [4:0] rsA, input logic [4:0] rtA,
                         input logic [4:0] rdA);
    bus32.idExValid          = v;
    bus32.writeBackControlIn = wb;
    bus32.memAccessControlIn = mem;
    bus32.calculationControl = calc;
    bus32.readData1          = rd1;
    bus32.readData2          = rd2;
    bus32.immediateOperand   = imm;
    bus32.rs                 = rsA;
    bus32.rt                 = rtA;
    bus32.rdIn               = rdA;
  endtask

  task automatic memwb32(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus32.memWbRegWrite = we;
    bus32.memWbRd       = rd;
    bus32.memWbData     = data;
  endtask

  task automatic drive8(input logic v, input logic [3:0] calc, input logic [7:0] rd1,
                        input logic [7:0] rd2, input logic [7:0] imm, input logic [4:0] rdA);
    bus8.idExValid          = v;
    bus8.writeBackControlIn = 2'b10;
    bus8.memAccessControlIn = 2'b00;
    bus8.calculationControl = calc;
    bus8.readData1          = rd1;
    bus8.readData2          = rd2;
    bus8.immediateOperand   = imm;
    bus8.rs                 = 5'd1;
    bus8.rt                 = 5'd2;
    bus8.rdIn               = rdA;
  endtask

  // Counts stall cycles (bounded) and bubble edges that leaked a valid.
  task automatic run_mult32(output int stall_cycles, output int leaks);
    stall_cycles = 0;
    leaks = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus32.stall !== 1'b1) break;
      stall_cycles++;
      step();
      if (bus32.exMemValid !== 1'b0) leaks++;
    end
  endtask

  task automatic run_mult8(output int stall_cycles);
    stall_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus8.stall !== 1'b1) break;
      stall_cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (bus32.exMemValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got=%b want=0", bus32.exMemValid); end
    tests_run++; if (bus32.result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_result: got=%h want=0", bus32.result); end
    tests_run++; if (bus32.rdOut !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_rd: got=%0d want=0", bus32.rdOut); end
    tests_run++; if (bus32.writeBackControlOut !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_wb: got=%b want=00", bus32.writeBackControlOut); end
    tests_run++; if (bus32.stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got=%b want=0", bus32.stall); end
    tests_run++; if (bus8.result !== 8'h0) begin tests_failed++; $display("[TB] FAIL reset_result8: got=%h want=0", bus8.result); end
    rstN = 1'b1;
    step();
  endtask

  task automatic test_alu();
    logic [3:0]  calc_v [8] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0001, 4'b1100};
    logic [31:0] imm_v  [8] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h2B, 32'h1, 32'h27};
    logic [31:0] a_v    [8] = '{32'd5, 32'd5, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] b_v    [8] = '{32'd7, 32'd7, 32'hFF00, 32'hFF00, 32'h1, 32'h1, 32'h0, 32'h0};
    logic [31:0] exp_v  [8] = '{32'd12, 32'hFFFFFFFE, 32'hF000, 32'hFFF0, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF};
    logic [4:0]  rd_v   [8] = '{5'd13, 5'd13, 5'd13, 5'd13, 5'd13, 5'd13, 5'd12, 5'd13};
    memwb32(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive32(1'b1, 2'b01, 2'b10, calc_v[i], a_v[i], b_v[i], imm_v[i], 5'd11, 5'd12, 5'd13);
      step();
      tests_run++; if (bus32.result !== exp_v[i]) begin tests_failed++; $display("[TB] FAIL alu_result[%0d]: got=%h want=%h", i, bus32.result, exp_v[i]); end
      tests_run++; if (bus32.rdOut !== rd_v[i]) begin tests_failed++; $display("[TB] FAIL alu_rd[%0d]: got=%0d want=%0d", i, bus32.rdOut, rd_v[i]); end
      tests_run++; if (bus32.writeData !== b_v[i]) begin tests_failed++; $display("[TB] FAIL alu_wdata[%0d]: got=%h want=%h", i, bus32.writeData, b_v[i]); end
    end
    tests_run++; if ({bus32.exMemValid, bus32.writeBackControlOut, bus32.memAccessControlOut} !== 5'b1_01_10) begin tests_failed++; $display("[TB] FAIL alu_ctrl: got=%b want=10110", {bus32.exMemValid, bus32.writeBackControlOut, bus32.memAccessControlOut}); end
  endtask

  task automatic test_forwarding();
    drive32(1'b0, 2'b00, 2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    memwb32(1'b0, 5'd0, 32'h0);
    step();
    // addi r5,r0,7 then add r6,r5,r0 with MEM/WB also writing r5=3
    drive32(1'b1, 2'b10, 2'b00, 4'b0001, 32'h0, 32'h0, 32'd7, 5'd0, 5'd5, 5'd0);
    step();
    memwb32(1'b1, 5'd5, 32'd3);
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'd100, 32'h0, 32'h20, 5'd5, 5'd0, 5'd6);
    step();
    tests_run++; if (bus32.result !== 32'd7) begin tests_failed++; $display("[TB] FAIL fwd_exmem_priority: got=%h want=%h", bus32.result, 32'd7); end
    tests_run++; if (bus32.rdOut !== 5'd6) begin tests_failed++; $display("[TB] FAIL fwd_rd: got=%0d want=6", bus32.rdOut); end
    // EX/MEM now targets r6, so the MEM/WB copy of r5 is used
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'd100, 32'h0, 32'h20, 5'd5, 5'd0, 5'd7);
    step();
    tests_run++; if (bus32.result !== 32'd3) begin tests_failed++; $display("[TB] FAIL fwd_memwb: got=%h want=%h", bus32.result, 32'd3); end
    // writes to r0 must never be forwarded
    memwb32(1'b1, 5'd0, 32'd3);
    drive32(1'b1, 2'b10, 2'b00, 4'b0001, 32'h0, 32'h0, 32'd9, 5'd0, 5'd0, 5'd0);
    step();
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'd11, 32'h0, 32'h20, 5'd0, 5'd0, 5'd6);
    step();
    tests_run++; if (bus32.result !== 32'd11) begin tests_failed++; $display("[TB] FAIL fwd_no_r0: got=%h want=%h", bus32.result, 32'd11); end
    // a bubble in EX/MEM holds its data but must not forward
    memwb32(1'b0, 5'd0, 32'h0);
    drive32(1'b1, 2'b10, 2'b00, 4'b0001, 32'h0, 32'h0, 32'd7, 5'd0, 5'd5, 5'd0);
    step();
    drive32(1'b0, 2'b10, 2'b00, 4'b0001, 32'h0, 32'h0, 32'd55, 5'd0, 5'd5, 5'd0);
    step();
    tests_run++; if ({bus32.exMemValid, bus32.writeBackControlOut} !== 3'b000) begin tests_failed++; $display("[TB] FAIL bubble_ctrl: got=%b want=000", {bus32.exMemValid, bus32.writeBackControlOut}); end
    tests_run++; if (bus32.result !== 32'd7) begin tests_failed++; $display("[TB] FAIL bubble_hold: got=%h want=%h", bus32.result, 32'd7); end
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'd40, 32'h0, 32'h20, 5'd5, 5'd0, 5'd6);
    step();
    tests_run++; if (bus32.result !== 32'd40) begin tests_failed++; $display("[TB] FAIL fwd_after_bubble: got=%h want=%h", bus32.result, 32'd40); end
  endtask

  task automatic test_multu_small();
    int cyc, leaks;
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'h00010000, 32'h00010000, 32'h19, 5'd1, 5'd2, 5'd9);
    run_mult32(cyc, leaks);
    tests_run++; if (cyc != 33) begin tests_failed++; $display("[TB] FAIL mult_small_stall: got=%0d want=33", cyc); end
    step();
    tests_run++; if (bus32.result !== 32'h0) begin tests_failed++; $display("[TB] FAIL mult_small_lo: got=%h want=0", bus32.result); end
    tests_run++; if ({bus32.exMemValid, bus32.rdOut} !== {1'b1, 5'd9}) begin tests_failed++; $display("[TB] FAIL mult_small_wb: valid=%b rd=%0d want valid=1 rd=9", bus32.exMemValid, bus32.rdOut); end
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd10);
    step();
    tests_run++; if (bus32.result !== 32'h1) begin tests_failed++; $display("[TB] FAIL mfhi_small: got=%h want=1", bus32.result); end
  endtask

  task automatic test_multu_forward();
    int cyc, leaks;
    drive32(1'b1, 2'b10, 2'b00, 4'b0001, 32'h0, 32'h0, 32'd2, 5'd0, 5'd2, 5'd0);
    step();
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'hFFFFFFFF, 32'h55, 32'h19, 5'd3, 5'd2, 5'd9);
    run_mult32(cyc, leaks);
    tests_run++; if (cyc != 33) begin tests_failed++; $display("[TB] FAIL mult_wide_stall: got=%0d want=33", cyc); end
    tests_run++; if (leaks != 0) begin tests_failed++; $display("[TB] FAIL mult_wide_bubbles: valid edges=%0d want=0", leaks); end
    step();
    tests_run++; if (bus32.result !== 32'hFFFFFFFE) begin tests_failed++; $display("[TB] FAIL mult_wide_lo: got=%h want=fffffffe", bus32.result); end
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd10);
    step();
    tests_run++; if (bus32.result !== 32'h1) begin tests_failed++; $display("[TB] FAIL mfhi_wide: got=%h want=1", bus32.result); end
  endtask

  task automatic test_flush();
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'd3, 32'd4, 32'h19, 5'd1, 5'd2, 5'd9);
    step();
    repeat (9) step();
    bus32.flush = 1'b1;
    bus32.idExValid = 1'b0;
    step();
    bus32.flush = 1'b0;
    tests_run++; if (bus32.stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_stall: got=%b want=0", bus32.stall); end
    tests_run++; if ({bus32.exMemValid, bus32.writeBackControlOut} !== 3'b000) begin tests_failed++; $display("[TB] FAIL flush_bubble: got=%b want=000", {bus32.exMemValid, bus32.writeBackControlOut}); end
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd10);
    step();
    tests_run++; if (bus32.result !== 32'h1) begin tests_failed++; $display("[TB] FAIL flush_hi: got=%h want=1", bus32.result); end
  endtask

  task automatic test_reset_mid();
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'd3, 32'd4, 32'h19, 5'd1, 5'd2, 5'd9);
    repeat (5) step();
    rstN = 1'b0;
    bus32.idExValid = 1'b0;
    #2;
    tests_run++; if ({bus32.exMemValid, bus32.writeBackControlOut, bus32.rdOut} !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_mid_ctrl: got=%h want=00", {bus32.exMemValid, bus32.writeBackControlOut, bus32.rdOut}); end
    tests_run++; if (bus32.result !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_result: got=%h want=0", bus32.result); end
    tests_run++; if (bus32.stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_stall: got=%b want=0", bus32.stall); end
    step();
    rstN = 1'b1;
    drive32(1'b1, 2'b10, 2'b00, 4'b1100, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd10);
    step();
    tests_run++; if (bus32.result !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_hi: got=%h want=0", bus32.result); end
    drive32(1'b1, 2'b10, 2'b00, 4'b0001, 32'h0, 32'h0, 32'd5, 5'd0, 5'd1, 5'd0);
    step();
    tests_run++; if ({bus32.result, bus32.rdOut} !== {32'd5, 5'd1}) begin tests_failed++; $display("[TB] FAIL rst_addi: result=%h rd=%0d want result=5 rd=1", bus32.result, bus32.rdOut); end
  endtask

  task automatic test_param8();
    int cyc;
    drive8(1'b1, 4'b1100, 8'hFF, 8'hFF, 8'h19, 5'd9);
    run_mult8(cyc);
    tests_run++; if (cyc != 9) begin tests_failed++; $display("[TB] FAIL mult8_stall: got=%0d want=9", cyc); end
    step();
    tests_run++; if (bus8.result !== 8'h01) begin tests_failed++; $display("[TB] FAIL mult8_lo: got=%h want=01", bus8.result); end
    drive8(1'b1, 4'b1100, 8'h0, 8'h0, 8'h10, 5'd10);
    step();
    tests_run++; if (bus8.result !== 8'hFE) begin tests_failed++; $display("[TB] FAIL mfhi8: got=%h want=fe", bus8.result); end
  endtask

  initial begin
    bus32.flush = 1'b0;
    bus8.flush = 1'b0;
    bus8.memWbRegWrite = 1'b0;
    bus8.memWbRd = 5'd0;
    bus8.memWbData = 8'h0;
    drive32(1'b0, 2'b00, 2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    memwb32(1'b0, 5'd0, 32'h0);
    drive8(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 5'd0);
    test_reset();
    test_alu();
    test_forwarding();
    test_multu_small();
    test_multu_forward();
    test_flush();
    test_reset_mid();
    test_param8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/execute_multicycle.md
# execute_multicycle

Parametrised execute stage for the pipelined core, successor to the single-cycle execute stage. It sits between the ID/EX and EX/MEM pipeline registers and contains:
- two-level operand forwarding;
- the single-cycle ALU path;
- a new iterative unsigned multiplier, with a HI register and a `stall` handshake to the upstream stages.

Every register updates on the falling edge of `clk`, as elsewhere in the pipeline.

## Interface
- `DATA_W`, 32, datapath width (≥ 8)
- `REG_ADDR_W`, 5, register-address width
- `clk`  in  1  pipeline clock; all state updates on negedge
- `rstN`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous kill of the instruction in EX (including an in-flight multiply)
- `idExValid`  in  1  ID/EX holds a real instruction
- `writeBackControlIn`  in  2  [1]=regWrite, [0]=memToReg
- `memAccessControlIn`  in  2  memRead/memWrite
- `calculationControl`  in  4  [3]=regDst, [2:1]=aluOp, [0]=aluSrc
- `readData1`, `readData2`, `immediateOperand`  in  DATA_W  ID/EX operands; funct = `immediateOperand[5:0]`
- `rs`, `rt`, `rdIn`  in  REG_ADDR_W  register specifiers
- `memWbRegWrite`  in  1  MEM/WB write enable
- `memWbRd`  in  REG_ADDR_W  MEM/WB destination
- `memWbData`  in  DATA_W  MEM/WB write-back value
- `stall`  out  1  hold PC, IF/ID and ID/EX this cycle (combinational)
- `exMemValid`  out  1  EX/MEM holds a real instruction
- `writeBackControlOut`, `memAccessControlOut`  out  2  EX/MEM control
- `result`, `writeData`  out  DATA_W  EX/MEM ALU result and store data
- `rdOut`  out  REG_ADDR_W  EX/MEM destination

## Operation
**Forwarding**, per operand (rs → operand1, rt → readData2Forwarded):
- EX/MEM has priority. It applies when `writeBackControlOut[1]`, `exMemValid`, `rdOut`≠0 and `rdOut` matches.
- MEM/WB applies next, when `memWbRegWrite`, `memWbRd`≠0 and `memWbRd` matches.
- Otherwise the operand is the register-file value.
- Register 0 is never forwarded.

**Operand and destination selection:**
- operand2 = `immediateOperand` when `aluSrc`, else readData2Forwarded.
- rd = `rdIn` when `regDst`, else `rt`.

**Instruction classes:**
- `isMult` = `idExValid` & aluOp==2'b10 & funct==MULTU (6'h19).
- `isMfhi` = `idExValid` & aluOp==2'b10 & funct==MFHI (6'h10). Its result is HI.
- All other instructions go through the ALU in one cycle.

**FSM states:** IDLE, BUSY, DONE.
- IDLE, no `isMult`: EX/MEM loads the instruction's result, control, `writeData` and rd. `exMemValid` = `idExValid`.
- IDLE with `isMult`: the multiplier latches operand1 and operand2 (forwarded values), counter ← DATA_W, state ← BUSY. A bubble is written to EX/MEM.
- BUSY: one shift-add iteration per edge, counter decrements, bubble each edge. On the edge where counter==1 the final iteration runs and state ← DONE.
- DONE: EX/MEM loads the low DATA_W bits of the product with the MULTU control and rd. HI ← high DATA_W bits. State ← IDLE.
- `stall` = (IDLE & `isMult`) | BUSY.

**Bubble:** `exMemValid`, `writeBackControlOut` and `memAccessControlOut` are 0. `result`, `writeData` and `rdOut` hold their previous values.

**`flush`:** on the next edge the state goes to IDLE, a bubble is written to EX/MEM, and HI is unchanged. `flush` has priority over every FSM transition.

**Arithmetic:** the product is an unsigned 2·DATA_W-bit value. ALU results wrap modulo 2^DATA_W.

## Timing
- Reset (`rstN` low, asynchronous): state IDLE, counter 0, HI 0. All outputs 0 (`stall` 0 once the FSM is IDLE with no `isMult` present).
- Reset asserted mid-multiply aborts it with no HI update.
- ALU instruction latency: 1 edge to EX/MEM.
- MULTU occupies EX for DATA_W+2 edges. `stall` is high for DATA_W+1 cycles and drops in the DONE cycle. The product reaches EX/MEM on edge DATA_W+2.
- A MFHI issued right after MULTU reads the new HI, because HI updates on the same edge the MULTU leaves EX.
- Operands are captured on the first edge. Later changes in MEM/WB during BUSY do not affect the product.
- `idExValid`=0 while IDLE produces a bubble and never starts the FSM.

## Structure
- Package `exec_pkg`:
  - funct constants MULTU and MFHI;
  - aluOp R-type code;
  - forwarding-select constants (nominal, memWb, exMem);
  - FSM state enum.
- Sub-module `mul_iter`: the radix-2 shift-add multiplier. It owns the operand, accumulator and counter registers. Ports: start, flush, done, product[2·DATA_W-1:0].
- The existing `Alu` is generalised with a DATA_W parameter and instantiated for the single-cycle path.
- Forwarding is coded inline. The old forwarding unit lacks the register-0 and valid checks.

## Test plan
- **Forwarding priority.** Back-to-back writes to r5 (EX/MEM=7, MEM/WB=3), then `add r6,r5,r0` → `result`=7. Same sequence with `rdOut`=0 → r0 is not forwarded and `readData1` is used.
- **MULTU, small operands.** 0x00010000 × 0x00010000 (DATA_W=32) → `stall` high for 33 cycles, then `result`=0x00000000. A following MFHI gives `result`=0x00000001.
- **MULTU, wide operand with forwarding.** 0xFFFFFFFF × 2, with the 2 forwarded from EX/MEM → lo=0xFFFFFFFE, HI=0x00000001, and `exMemValid` was 0 during all 33 bubble edges.
- **Flush mid-multiply.** `flush` pulsed on BUSY cycle 10 → next edge IDLE, `stall`=0, bubble written, HI keeps its prior value.
- **Reset mid-multiply.** `rstN` pulsed low mid-BUSY → all outputs 0, HI 0, FSM IDLE. A subsequent `addi r1,r0,5` → `result`=5 after 1 edge.
- **Parametrisation.** DATA_W=8: 0xFF × 0xFF → lo=0x01, HI=0xFE, `stall` high for 9 cycles.
